layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Time-multiplexes one physical `layer` instance (NUM_NEURON neurons, NUM_INPUTS inputs each) across NUM_LAYERS logical network layers.
- Per layer it:
  - selects that layer's weight bank through an external registered weight memory,
  - drives the layer's active mask from a per-layer neuron count,
  - pulses the layer's start,
  - waits for all active neurons to report valid,
  - feeds the outputs back as the next layer's inputs.
- It sits between the top-level inference request and the `layer` datapath.

Parameters:
- NUM_LAYERS, 3, logical layers per inference.
- NUM_NEURON, 6, physical neurons in the shared layer.
- NUM_INPUTS, 6, inputs per neuron; must be >= NUM_NEURON.
- INPUT_SIZE, 9, width of one layer input.
- OUTPUT_SIZE, 10, width of one neuron output.
- SETTLE_CYCLES, 2, guard cycles after layer_start before out_valid is sampled.
- TIMEOUT, 1023, max WAIT cycles per layer; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  inference request; accepted only in IDLE.
- in_vector  in  NUM_INPUTS*INPUT_SIZE  network input; sampled on the accepted start.
- layer_sizes  in  NUM_LAYERS*CNT_W  neuron count per layer, CNT_W=$clog2(NUM_NEURON+1); layer k is at [k*CNT_W+:CNT_W]; must be stable while busy.
- weight_layer  out  LAYER_W  weight-bank index to the weight memory, LAYER_W=max(1,$clog2(NUM_LAYERS)).
- layer_start  out  1  one-cycle start pulse to the layer.
- layer_active  out  NUM_NEURON  active mask to the layer.
- layer_inputs  out  NUM_INPUTS*INPUT_SIZE  input bus to the layer.
- layer_values  in  NUM_NEURON*OUTPUT_SIZE  layer out_values.
- layer_valid  in  NUM_NEURON  layer out_valid.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the final layer has been stored.
- result  out  NUM_NEURON*OUTPUT_SIZE  final-layer outputs; held until the next accepted start.
- error  out  1  timeout flag; tied 0 unless LAYER_SEQ_TIMEOUT_EN is defined.

Behaviour:
- Reset values: state=IDLE; layer index 0; weight_layer 0; layer_start 0; layer_active 0; layer_inputs 0; busy 0; done 0; result 0; error 0.
- Reset has priority in every state, including mid-inference. It aborts the inference with no done pulse.
- States:
  - IDLE: on start, capture in_vector into the input buffer, set layer index 0, busy=1, go to FETCH.
  - FETCH (1 cycle): weight_layer = layer index; covers the weight memory's 1-cycle read latency. Also set layer_active = (1<<size_k)-1, where size_k = layer_sizes[k]; size_k > NUM_NEURON is clamped to NUM_NEURON.
  - START (1 cycle): layer_start=1.
  - SETTLE: count SETTLE_CYCLES cycles, then go to WAIT.
  - WAIT: leave when (layer_valid & layer_active) == layer_active.
    - An all-zero mask (size_k=0) completes in the first WAIT cycle.
  - STORE (1 cycle): write the feedback buffer.
    - Entry j, for j < size_k: value_j converted to INPUT_SIZE.
    - All other entries: 0, including inactive neurons and j >= NUM_NEURON.
    - If k == NUM_LAYERS-1: result = layer_values with inactive lanes zeroed; go to DONE.
    - Otherwise: k+1, go to FETCH.
  - DONE (1 cycle): done=1, busy=0, go to IDLE.
- Hold rules:
  - weight_layer, layer_active and layer_inputs are held stable from FETCH through STORE of each layer.
  - layer_inputs is driven directly from the buffer.
- Width conversion (values unsigned):
  - If OUTPUT_SIZE > INPUT_SIZE, saturate to 2^INPUT_SIZE-1 when any dropped MSB is set; otherwise take the low bits.
  - Otherwise zero-extend.
- start while busy is ignored.
- start in the same cycle as the DONE state is ignored; a new start is accepted from the following IDLE cycle.
- Latency per layer: 3 + SETTLE_CYCLES + W cycles, where W ≥ 1 is the number of WAIT cycles (WAIT is entered once, and that first WAIT cycle counts).
- Total latency: the sum over all layers, plus one DONE cycle.

Optional Feature:
- Macro: LAYER_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT counter resets on entry to WAIT.
  - If TIMEOUT cycles elapse without completion: set error=1 (sticky until the next accepted start or rst), go to DONE, pulse done.
  - result in that case: the current layer_values with inactive lanes zeroed.
- Undefined: no counter; error is constant 0; WAIT may last indefinitely.

Decomposition:
- Package `layer_seq_pkg`:
  - state encoding localparams: IDLE, FETCH, START, SETTLE, WAIT, STORE, DONE.
  - CNT_W and LAYER_W helper functions.
- One natural sub-module, `out_to_in_sat`: combinational OUTPUT_SIZE→INPUT_SIZE saturating converter, instantiated per neuron lane.

Test Plan:
- Reset mid-inference: rst asserted during WAIT of layer 1 → next cycle IDLE, all outputs 0, no done. A subsequent start runs a full inference normally.
- Nominal run: NUM_LAYERS=3, sizes {6,4,2}, in_vector lanes 0..5 = 1..6, layer model with valid 5 cycles after start → weight_layer steps 0,1,2; layer_active = 6'h3F, 6'h0F, 6'h03; done pulses exactly once at the computed latency.
- Saturation: layer returns 10'h3FF on lane 0 and 10'h0FF on lane 1 → next layer_inputs lanes = 9'h1FF and 9'h0FF; lanes ≥ size_k = 0.
- Zero-size layer: sizes {6,0,3} → layer 1 WAIT lasts 1 cycle regardless of layer_valid. Layer 2 inputs are all 0, because layer 1's stored feedback was all zero.
- Start handling: start pulsed while busy and in the DONE cycle → ignored, single done. Back-to-back start in the first IDLE cycle is accepted, and result is held until that new start.
- Timeout (LAYER_SEQ_TIMEOUT_EN, TIMEOUT=20): layer_valid never asserted → after 20 WAIT cycles, error=1 and done pulses. The next start clears error.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared types and width helpers for the layer sequencer and its interface.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    SETTLE,
    WAIT,
    STORE,
    DONE
  } state_e;

  // Bits needed to hold a neuron count 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n layers, never less than one.
  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Bus between the sequencer (master) and the shared layer datapath plus weight memory (slave).
interface layer_sequencer_if
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS  = 3,
  parameter int NUM_NEURON  = 6,
  parameter int NUM_INPUTS  = 6,
  parameter int INPUT_SIZE  = 9,
  parameter int OUTPUT_SIZE = 10
);

  localparam int LAYER_W = layer_w(NUM_LAYERS);

  logic [LAYER_W-1:0]                weight_layer;
  logic                              layer_start;
  logic [NUM_NEURON-1:0]             layer_active;
  logic [NUM_INPUTS*INPUT_SIZE-1:0]  layer_inputs;
  logic [NUM_NEURON*OUTPUT_SIZE-1:0] layer_values;
  logic [NUM_NEURON-1:0]             layer_valid;

  modport master (
    output weight_layer, layer_start, layer_active, layer_inputs,
    input  layer_values, layer_valid
  );

  modport slave (
    input  weight_layer, layer_start, layer_active, layer_inputs,
    output layer_values, layer_valid
  );

endinterface

// File: rtl/out_to_in_sat.sv
// Unsigned width converter from a neuron output to a layer input: saturates when narrowing, zero-extends otherwise.
module out_to_in_sat #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 9
) (
  input  logic [IN_W-1:0]  value_i,
  output logic [OUT_W-1:0] value_o
);

  generate
    if (IN_W > OUT_W) begin : g_sat
      assign value_o = (|value_i[IN_W-1:OUT_W]) ? '1 : value_i[OUT_W-1:0];
    end else begin : g_ext
      assign value_o = OUT_W'(value_i);
    end
  endgenerate

endmodule

// File: rtl/layer_sequencer.sv
// Runs NUM_LAYERS logical layers through one shared layer instance, feeding outputs back as inputs.
// Optional WAIT timeout with sticky error flag is built when LAYER_SEQ_TIMEOUT_EN is defined.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int  NUM_LAYERS    = 3,
  parameter int  NUM_NEURON    = 6,
  parameter int  NUM_INPUTS    = 6,
  parameter int  INPUT_SIZE    = 9,
  parameter int  OUTPUT_SIZE   = 10,
  parameter int  SETTLE_CYCLES = 2,
  parameter int  TIMEOUT       = 1023,
  localparam int CNT_W         = cnt_w(NUM_NEURON),
  localparam int LAYER_W       = layer_w(NUM_LAYERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0]  in_vector,
  input  logic [NUM_LAYERS*CNT_W-1:0]       layer_sizes,
  layer_sequencer_if.master                 lyr,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_NEURON*OUTPUT_SIZE-1:0] result,
  output logic                              error
);

  localparam int                 SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LAYER_W-1:0] LAST  = LAYER_W'(NUM_LAYERS - 1);

  typedef logic [NUM_NEURON-1:0] mask_t;

  state_e                                 state_q, state_d;
  logic [LAYER_W-1:0]                     layer_q, layer_d;
  mask_t                                  active_q, active_d;
  logic [NUM_INPUTS-1:0][INPUT_SIZE-1:0]  fb_q, fb_d;
  logic [NUM_NEURON-1:0][OUTPUT_SIZE-1:0] result_q, result_d;
  logic [SET_W-1:0]                       settle_q, settle_d;
  logic                                   start_q, start_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;

  logic [NUM_NEURON-1:0][OUTPUT_SIZE-1:0] values;
  logic [NUM_NEURON-1:0][OUTPUT_SIZE-1:0] masked;
  logic [NUM_NEURON-1:0][INPUT_SIZE-1:0]  conv;
  logic [CNT_W-1:0]                       sizes [NUM_LAYERS];
  logic                                   layer_ok;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_q, wait_d;
  logic            error_q, error_d;
`endif

  // Counts above NUM_NEURON saturate to a full mask since every lane index is below them.
  function automatic mask_t mask_of(input logic [CNT_W-1:0] size);
    mask_t m;
    for (int j = 0; j < NUM_NEURON; j++) m[j] = (j < int'(size));
    return m;
  endfunction

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_size
    assign sizes[k] = layer_sizes[k*CNT_W +: CNT_W];
  end

  assign values = lyr.layer_values;

  for (genvar j = 0; j < NUM_NEURON; j++) begin : g_lane
    out_to_in_sat #(
      .IN_W  (OUTPUT_SIZE),
      .OUT_W (INPUT_SIZE)
    ) u_sat (
      .value_i (values[j]),
      .value_o (conv[j])
    );
    assign masked[j] = active_q[j] ? values[j] : '0;
  end

  assign layer_ok = ((lyr.layer_valid & active_q) == active_q);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    layer_d  = layer_q;
    active_d = active_q;
    fb_d     = fb_q;
    result_d = result_q;
    settle_d = settle_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
    wait_d   = (state_q == WAIT) ? wait_q : '0;
    error_d  = error_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          fb_d     = in_vector;
          layer_d  = '0;
          active_d = mask_of(sizes[0]);
          state_d  = FETCH;
`ifdef LAYER_SEQ_TIMEOUT_EN
          error_d  = 1'b0;
`endif
        end
      end
      FETCH: state_d = START;
      START: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? WAIT : SETTLE;
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = WAIT;
        else settle_d = settle_q + SET_W'(1);
      end
      WAIT: begin
        if (layer_ok) begin
          state_d = STORE;
`ifdef LAYER_SEQ_TIMEOUT_EN
        end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
          error_d  = 1'b1;
          result_d = masked;
          state_d  = DONE;
        end else begin
          wait_d = wait_q + TO_W'(1);
`endif
        end
      end
      STORE: begin
        for (int j = 0; j < NUM_INPUTS; j++) fb_d[j] = '0;
        for (int j = 0; j < NUM_NEURON; j++) if (active_q[j]) fb_d[j] = conv[j];
        if (layer_q == LAST) begin
          result_d = masked;
          state_d  = DONE;
        end else begin
          layer_d  = layer_q + LAYER_W'(1);
          active_d = mask_of(sizes[layer_q + LAYER_W'(1)]);
          state_d  = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered off the next state so they line up with it glitch-free.
    start_d = (state_d == START);
    busy_d  = state_d inside {FETCH, START, SETTLE, WAIT, STORE};
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: the feedback buffer and result are reset too, so every output reads 0 right after rst.
    if (rst) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      active_q <= '0;
      fb_q     <= '0;
      result_q <= '0;
      settle_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wait_q   <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state_q  <= state_d;
      layer_q  <= layer_d;
      active_q <= active_d;
      fb_q     <= fb_d;
      result_q <= result_d;
      settle_q <= settle_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wait_q   <= wait_d;
      error_q  <= error_d;
`endif
    end
  end

  assign lyr.weight_layer = layer_q;
  assign lyr.layer_start  = start_q;
  assign lyr.layer_active = active_q;
  assign lyr.layer_inputs = fb_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign result           = result_q;

`ifdef LAYER_SEQ_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a behavioural layer model answering 5 cycles after each start.
`timescale 1ns/1ps
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int NL = 3, NN = 6, NI = 6, IS = 9, OS = 10, SC = 2;
  localparam int CW = 3, LW = 2, DLY = 5;
`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic              clk = 1'b0;
  logic              rst, start;
  logic [NI*IS-1:0]  in_vector;
  logic [NL*CW-1:0]  layer_sizes;
  logic              busy, done, error;
  logic [NN*OS-1:0]  result;

  layer_sequencer_if #(.NUM_LAYERS(NL), .NUM_NEURON(NN), .NUM_INPUTS(NI),
                       .INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) lyr ();

  layer_sequencer #(
    .NUM_LAYERS(NL), .NUM_NEURON(NN), .NUM_INPUTS(NI), .INPUT_SIZE(IS),
    .OUTPUT_SIZE(OS), .SETTLE_CYCLES(SC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_vector(in_vector),
    .layer_sizes(layer_sizes), .lyr(lyr), .busy(busy), .done(done),
    .result(result), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Layer model: per-bank output table, all lanes valid DLY cycles after layer_start.
  logic [OS-1:0] vtab [NL][NN];
  logic          valid_en = 1'b1;
  int            mcnt = -1;

  always @(negedge clk) begin
    if (rst) begin
      lyr.layer_valid  = '0;
      lyr.layer_values = '0;
      mcnt = -1;
    end else if (lyr.layer_start) begin
      lyr.layer_valid = '0;
      mcnt = 0;
      for (int j = 0; j < NN; j++) lyr.layer_values[j*OS +: OS] = vtab[lyr.weight_layer][j];
    end else if (mcnt >= 0) begin
      mcnt++;
      if (mcnt == DLY && valid_en) lyr.layer_valid = '1;
    end
  end

  logic [LW-1:0]    log_wl  [NL];
  logic [NN-1:0]    log_act [NL];
  logic [NI*IS-1:0] log_in  [NL];
  int               n_starts;

  // Called at a negedge; asserts start for one cycle and follows the run up to its DONE cycle.
  task automatic run(input int exp_lat, input int poke_cyc, input int exp_starts);
    bit seen = 0;
    n_starts = 0;
    start = 1'b1;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      start = (c == poke_cyc);
      if (c == 1) check("busy_rise", busy, 1);
      if (lyr.layer_start && n_starts < NL) begin
        log_wl[n_starts]  = lyr.weight_layer;
        log_act[n_starts] = lyr.layer_active;
        log_in[n_starts]  = lyr.layer_inputs;
        n_starts++;
      end
      if (done) begin
        seen = 1;
        check("latency", c, exp_lat);
        check("starts", n_starts, exp_starts);
        check("busy_at_done", busy, 0);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic check_layers(input logic [NN-1:0] a0, a1, a2,
                              input logic [NI*IS-1:0] i1, i2);
    logic [NN-1:0]    ea [NL];
    logic [NI*IS-1:0] ei [NL];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    ei[0] = in_vector; ei[1] = i1; ei[2] = i2;
    for (int k = 0; k < NL; k++) begin
      check($sformatf("wl%0d", k), log_wl[k], k);
      check($sformatf("act%0d", k), log_act[k], ea[k]);
      check($sformatf("inputs%0d", k), log_in[k], ei[k]);
    end
  endtask

  task automatic after_done(input logic [NN*OS-1:0] exp_res);
    check("result", result, exp_res);
    check("error_clear", error, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("busy_idle", busy, 0);
  endtask

  localparam logic [NL*CW-1:0] SZ_NOM  = {3'd2, 3'd4, 3'd6};
  localparam logic [NL*CW-1:0] SZ_ZERO = {3'd3, 3'd0, 3'd6};
  localparam logic [NI*IS-1:0] VEC     = {9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1};
  localparam logic [NI*IS-1:0] IN1     = {9'h005, 9'h1FF, 9'h1FF, 9'h100, 9'h0FF, 9'h1FF};
  localparam logic [NI*IS-1:0] IN2_NOM = {9'h000, 9'h000, 9'h022, 9'h011, 9'h0FF, 9'h1FF};
  localparam logic [NN*OS-1:0] RES_NOM = {10'h0, 10'h0, 10'h0, 10'h0, 10'h045, 10'h123};
  localparam logic [NN*OS-1:0] RES_ZER = {10'h0, 10'h0, 10'h0, 10'h3AA, 10'h045, 10'h123};

  initial begin
    vtab[0] = '{10'h3FF, 10'h0FF, 10'h100, 10'h1FF, 10'h200, 10'h005};
    vtab[1] = '{10'h3FF, 10'h0FF, 10'h011, 10'h022, 10'h033, 10'h044};
    vtab[2] = '{10'h123, 10'h045, 10'h3AA, 10'h3BB, 10'h3CC, 10'h3DD};
    rst = 1'b1; start = 1'b0; in_vector = '0; layer_sizes = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wl", lyr.weight_layer, 0);
    check("rst_lstart", lyr.layer_start, 0);
    check("rst_active", lyr.layer_active, 0);
    check("rst_inputs", lyr.layer_inputs, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal three-layer run, including saturation of 3FF and 200 on feedback.
    in_vector = VEC; layer_sizes = SZ_NOM;
    run(25, 0, NL);
    check_layers(6'h3F, 6'h0F, 6'h03, IN1, IN2_NOM);
    after_done(RES_NOM);

    // Zero-size middle layer completes on its first WAIT cycle and feeds back all zeros.
    layer_sizes = SZ_ZERO;
    run(23, 0, NL);
    check_layers(6'h3F, 6'h00, 6'h07, IN1, '0);
    after_done(RES_ZER);

    // Start while busy and during DONE is ignored; first IDLE cycle start is accepted.
    layer_sizes = SZ_NOM;
    run(25, 4, NL);
    start = 1'b1;
    @(negedge clk);
    check("done_cycle_start_ignored", busy, 0);
    check("single_done", done, 0);
    check("result_held", result, RES_NOM);
    run(25, 0, NL);
    check_layers(6'h3F, 6'h0F, 6'h03, IN1, IN2_NOM);
    after_done(RES_NOM);

    // Reset during the first WAIT cycle of layer 1 aborts with no done.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_wl", lyr.weight_layer, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wl", lyr.weight_layer, 0);
    check("abort_active", lyr.layer_active, 0);
    check("abort_inputs", lyr.layer_inputs, 0);
    check("abort_result", result, 0);
    begin
      int spurious = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy || lyr.layer_start) spurious++;
      end
      check("abort_quiet", spurious, 0);
    end
    run(25, 0, NL);
    check_layers(6'h3F, 6'h0F, 6'h03, IN1, IN2_NOM);
    after_done(RES_NOM);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Layer never reports valid: layer 0 gives up after TO WAIT cycles.
    valid_en = 1'b0;
    run(3 + SC + TO, 0, 1);
    check("to_error", error, 1);
    check("to_result", result, {10'h005, 10'h200, 10'h1FF, 10'h100, 10'h0FF, 10'h3FF});
    @(negedge clk);
    check("to_error_sticky", error, 1);
    valid_en = 1'b1;
    run(25, 0, NL);
    after_done(RES_NOM);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
